// File: rtl/vscale_mul_div_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// retiring BITS_PER_CYCLE result bits per compute cycle, with backpressure and abort.
module vscale_mul_div_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_in_1,
    input  logic [XLEN-1:0] req_in_2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SETUP, S_DONE} state_t;

    // Handshake: a request is taken on a rising edge with req_valid && req_ready; a response
    // is consumed on a rising edge with resp_valid && resp_ready. resp_result is stable in DONE.
    state_t            state;
    logic [2:0]        op;
    logic              neg_out;
    logic              div_zero;
    logic [XLEN-1:0]   in1_raw;
    logic [XLEN-1:0]   a_q;      // multiplicand, or dividend shifting out / quotient shifting in
    logic [XLEN-1:0]   b_q;      // multiplier shifting MSB-first, or divisor
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt;

    // Request decode
    logic            sgn1_sel, sgn2_sel, s1, s2, req_div_zero, req_neg;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        sgn1_sel     = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                       (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        sgn2_sel     = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        s1           = sgn1_sel && req_in_1[XLEN-1];
        s2           = sgn2_sel && req_in_2[XLEN-1];
        mag1         = s1 ? -req_in_1 : req_in_1;
        mag2         = s2 ? -req_in_2 : req_in_2;
        req_neg      = (req_funct3 == 3'd6) ? s1 : (s1 ^ s2);
        req_div_zero = req_funct3[2] && (req_in_2 == '0);
    end

    // One compute cycle: BITS_PER_CYCLE multiply or restoring-divide steps
    logic [2*XLEN-1:0] mul_acc_n;
    logic [XLEN-1:0]   mul_b_n;
    logic [XLEN-1:0]   div_r, div_q;
    logic [XLEN:0]     div_t;

    always_comb begin
        mul_acc_n = acc_q << BITS_PER_CYCLE;
        mul_b_n   = b_q << BITS_PER_CYCLE;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_q[XLEN-1-j])
                mul_acc_n = mul_acc_n + ({{XLEN{1'b0}}, a_q} << (BITS_PER_CYCLE - 1 - j));
        end
        div_r = rem_q;
        div_q = a_q;
        div_t = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            div_t = {div_r, div_q[XLEN-1]};
            div_q = div_q << 1;
            if (div_t >= {1'b0, b_q}) begin
                div_t    = div_t - {1'b0, b_q};
                div_q[0] = 1'b1;
            end
            div_r = div_t[XLEN-1:0];
        end
    end

    // Sign correction and output selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, final_result;

    always_comb begin
        prod = neg_out ? -acc_q : acc_q;
        quo  = neg_out ? -a_q : a_q;
        rmd  = neg_out ? -rem_q : rem_q;
        case (op)
            3'd0:          final_result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    final_result = div_zero ? '1 : quo;
            default:       final_result = div_zero ? in1_raw : rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= '0;
            neg_out     <= 1'b0;
            div_zero    <= 1'b0;
            in1_raw     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            resp_result <= '0;
        end else if (kill && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op       <= req_funct3;
                        neg_out  <= req_neg;
                        div_zero <= req_div_zero;
                        in1_raw  <= req_in_1;
                        a_q      <= mag1;
                        b_q      <= mag2;
                        rem_q    <= '0;
                        acc_q    <= '0;
                        cnt      <= CW'(STEPS - 1);
                        state    <= req_div_zero ? S_SETUP : S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (op[2]) begin
                        rem_q <= div_r;
                        a_q   <= div_q;
                    end else begin
                        acc_q <= mul_acc_n;
                        b_q   <= mul_b_n;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= S_SETUP;
                end
                S_SETUP: begin
                    resp_result <= final_result;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE) && !reset;
    assign resp_valid = (state == S_DONE) && !reset;

endmodule

// File: tb/tb_vscale_mul_div_iter.sv
// Bench for vscale_mul_div_iter: directed and model-checked ops pushed to a scoreboard queue,
// a negedge monitor compares results, response latency, hold stability and req_ready in DONE.
module tb_vscale_mul_div_iter;
  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int LAT  = XLEN / BPC + 2;
  localparam logic [XLEN-1:0] ALL1 = '1;
  localparam logic [XLEN-1:0] MINF = {1'b1, {(XLEN-1){1'b0}}};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic [XLEN-1:0] req_in_1 = '0;
  logic [XLEN-1:0] req_in_2 = '0;
  logic            kill = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] resp_result;

  vscale_mul_div_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_in_1(req_in_1), .req_in_2(req_in_2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] exp_q[$];
  int lat_q[$];
  int acc_cyc = 0;
  logic prev_v = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic signed [2*XLEN+1:0] sa, sb, p, q, r;
    logic s1, s2;
    s1 = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    s2 = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    sa = s1 ? {{(XLEN+2){a[XLEN-1]}}, a} : {{(XLEN+2){1'b0}}, a};
    sb = s2 ? {{(XLEN+2){b[XLEN-1]}}, b} : {{(XLEN+2){1'b0}}, b};
    if (!f3[2]) begin
      p = sa * sb;
      return (f3 == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end
    if (b == '0) return f3[1] ? a : ALL1;
    q = sa / sb;
    r = sa % sb;
    return f3[1] ? r[XLEN-1:0] : q[XLEN-1:0];
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", XLEN'(resp_valid), '0);
        end else begin
          if (!prev_v) check("latency", XLEN'(cyc - acc_cyc), XLEN'(lat_q[0]));
          check("req_ready_in_done", XLEN'(req_ready), '0);
          if (resp_ready) begin
            check("result", resp_result, exp_q.pop_front());
            void'(lat_q.pop_front());
          end else begin
            check("result_hold", resp_result, exp_q[0]);
          end
        end
      end
      prev_v = resp_valid;
    end
  end

  // driver: issue one op, optionally with kill on the accept edge or response held back
  task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input logic kill_acc,
                       input int hold);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_issue", XLEN'(req_ready), XLEN'(1));
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_cyc = cyc;
    req_valid = 1'b1;
    req_funct3 = f3;
    req_in_1 = a;
    req_in_2 = b;
    kill = kill_acc;
    if (hold > 0) resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    kill = 1'b0;
    req_funct3 = 3'($urandom_range(0, 7));
    req_in_1 = XLEN'({$urandom(), $urandom()});
    req_in_2 = XLEN'({$urandom(), $urandom()});
    if (hold > 0) begin
      guard = 0;
      while (!resp_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", XLEN'(exp_q.size()), '0);
      exp_q.delete();
      lat_q.delete();
    end
    resp_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] f3;
    logic [XLEN-1:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", XLEN'(req_ready), '0);
    check("reset_resp_valid", XLEN'(resp_valid), '0);
    check("reset_resp_result", resp_result, '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", XLEN'(req_ready), XLEN'(1));

    do_op(3'd0, XLEN'(7), XLEN'(6), XLEN'(42), LAT, 1'b0, 0);
    do_op(3'd3, ALL1, ALL1, ALL1 - XLEN'(1), LAT, 1'b0, 0);
    do_op(3'd1, ALL1, XLEN'(2), ALL1, LAT, 1'b0, 0);
    do_op(3'd2, ALL1, ALL1, ALL1, LAT, 1'b0, 0);
    do_op(3'd0, XLEN'(-3), XLEN'(5), XLEN'(-15), LAT, 1'b0, 0);
    do_op(3'd4, XLEN'(-7), XLEN'(2), XLEN'(-3), LAT, 1'b0, 0);
    do_op(3'd6, XLEN'(-7), XLEN'(2), XLEN'(-1), LAT, 1'b0, 0);
    do_op(3'd5, XLEN'(100), XLEN'(7), XLEN'(14), LAT, 1'b0, 0);
    do_op(3'd7, XLEN'(100), XLEN'(7), XLEN'(2), LAT, 1'b0, 0);
    do_op(3'd4, MINF, ALL1, MINF, LAT, 1'b0, 0);
    do_op(3'd6, MINF, ALL1, '0, LAT, 1'b0, 0);
    do_op(3'd5, XLEN'(5), '0, ALL1, 2, 1'b0, 0);
    do_op(3'd6, XLEN'(-5), '0, XLEN'(-5), 2, 1'b0, 0);
    do_op(3'd0, XLEN'(123), XLEN'(1000), XLEN'(123000), LAT, 1'b0, 10);
    do_op(3'd0, XLEN'(11), XLEN'(13), XLEN'(143), LAT, 1'b1, 0);

    // abort mid-compute: no response may follow
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = 3'd0;
    req_in_1 = XLEN'(3);
    req_in_2 = XLEN'(5);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_req_ready", XLEN'(req_ready), XLEN'(1));
    check("kill_resp_valid", XLEN'(resp_valid), '0);
    repeat (LAT + 5) @(negedge clk);
    do_op(3'd0, XLEN'(3), XLEN'(3), XLEN'(9), LAT, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = XLEN'({$urandom(), $urandom()});
      b = (i % 5 == 4) ? '0 : XLEN'({$urandom(), $urandom()});
      if (i % 4 == 1) b = XLEN'($urandom_range(1, 9));
      do_op(f3, a, b, model(f3, a, b), (f3[2] && b == '0) ? 2 : LAT, 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vscale_mul_div_iter.md
Name: vscale_mul_div_iter

Overview:
- Parametrised iterative integer multiply/divide unit for the vscale pipeline; successor to the 1-bit/cycle shift-add/restoring-divide unit.
- Generalised in operand width (XLEN) and radix: BITS_PER_CYCLE result bits retired per compute cycle.
- Adds full RV32M/RV64M op decode, spec-defined divide-by-zero, response backpressure and abort.
- Sits beside the ALU in the execute stage; the pipeline stalls on req_ready/resp_valid.

Parameters:
- XLEN, 32, operand and result width; must be a power of 2, ≥8.
- BITS_PER_CYCLE, 1, bits processed per compute cycle; one of 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_funct3  in  3  RISC-V M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_in_1  in  XLEN  rs1 (multiplicand/dividend).
- req_in_2  in  XLEN  rs2 (multiplier/divisor).
- kill  in  1  abort the in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  XLEN  result.

Behaviour:
- States: IDLE, COMPUTE, SETUP, DONE. Reset → IDLE. During reset: req_ready=0, resp_valid=0, resp_result=0. Reset mid-operation abandons the operation with no response.
- req_ready = (state==IDLE) && !reset. resp_valid = (state==DONE).
- Accept when req_valid && req_ready at a rising edge. Operands and funct3 are latched; inputs are ignored afterwards.
- Signedness:
  - in_1 is signed for MULH, MULHSU, DIV, REM.
  - in_2 is signed for MULH, DIV, REM.
  - MUL ignores sign (low half).
- Operands are converted to magnitude (2XLEN-wide datapath). negate_output is:
  - REM: sign_1.
  - DIV/MUL*: sign_1 ^ sign_2.
- Multiply: each compute cycle adds BITS_PER_CYCLE shifted partial products, scanning the multiplier MSB-first. Output selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits, after negation of the full 2XLEN product.
- Divide: restoring. Each compute cycle chains BITS_PER_CYCLE compare/subtract steps combinationally, producing BITS_PER_CYCLE quotient bits MSB-first. Output selection:
  - DIV/DIVU: quotient.
  - REM/REMU: remainder, each negated per negate_output.
- Latency: COMPUTE lasts exactly XLEN/BITS_PER_CYCLE cycles (internal counter loaded with XLEN/BITS_PER_CYCLE-1, leaves at 0), then 1 cycle SETUP, then DONE. resp_valid first high XLEN/BITS_PER_CYCLE+2 cycles after the accept edge (34 for defaults).
- Divide by zero (in_2==0, any div/rem op): IDLE → SETUP directly, bypassing COMPUTE; latency 2.
  - Quotient = all ones.
  - Remainder = in_1 unmodified.
  - No negation is applied.
- Signed overflow (DIV/REM, in_1 = -2^(XLEN-1), in_2 = -1): normal path. Quotient = in_1, remainder 0; no special case required, but this must hold.
- DONE holds resp_result and resp_valid stable until resp_valid && resp_ready, then → IDLE. req_ready rises the cycle after the response handshake; no back-to-back accept in the same cycle.
- kill in COMPUTE/SETUP/DONE → IDLE next edge, no response issued. kill in IDLE has no effect, and a simultaneous req_valid is still accepted. reset has priority over kill.
- resp_result is a registered output; it changes only on entry to DONE (or on reset).

Test Plan:
- Defaults, MUL 7×6 → resp_result=42, resp_valid exactly 34 cycles after accept; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0xFFFFFFFF(-1)×2 → 0xFFFFFFFF; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MUL -3×5 → 0xFFFFFFF1.
- DIV -7/2 → 0xFFFFFFFD, REM -7/2 → 0xFFFFFFFF, DIVU 100/7 → 14, REMU 100/7 → 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same → 0.
- DIVU 5/0 → 0xFFFFFFFF, REM -5/0 → 0xFFFFFFFB, resp_valid 2 cycles after accept.
- resp_ready held 0 for 10 cycles in DONE → result stable, req_ready=0; kill at compute cycle 5 → IDLE next cycle, no resp_valid, next request 3×3 → 9.
- Rerun the above with XLEN=64, BITS_PER_CYCLE=4 → identical values (sign-extended), latency 18; random compare against a reference model for all funct3.
